// File: rtl/nanci_collect_pkg.sv
// Shared state encoding and word-width helper for the Nanci result collector.
// Imported by nanci_word_select and nanci_result_collector.
package nanci_collect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int word_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/nanci_word_select.sv
// Combinational slice picker: selects PE word [idx_i] from the column, splits it
// into addr/data and flags the all-ones-address null slot marker.
module nanci_word_select
  import nanci_collect_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [NUM_PE*word_width(ADDR_WIDTH, DATA_WIDTH)-1:0] col_i,
  input  logic [IDX_WIDTH-1:0]                                  idx_i,
  output logic [ADDR_WIDTH-1:0]                                 addr_o,
  output logic [DATA_WIDTH-1:0]                                 data_o,
  output logic                                                  null_o
);

  localparam int WW = word_width(ADDR_WIDTH, DATA_WIDTH);

  logic [WW-1:0] word;

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (idx_i == IDX_WIDTH'(k)) word = col_i[k*WW +: WW];
    end
  end

  assign addr_o = word[WW-1 -: ADDR_WIDTH];
  assign data_o = word[DATA_WIDTH-1:0];
  assign null_o = &addr_o;

endmodule

// File: rtl/nanci_result_collector.sv
// Snapshots one PE column on i_capture and drains it one word per cycle on a
// valid/ready stream. NANCI_COLLECT_FILTER_EN skips all-ones-address words.
module nanci_result_collector
  import nanci_collect_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int IDX_WIDTH  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [NUM_PE*word_width(ADDR_WIDTH, DATA_WIDTH)-1:0]  i_PE_col,
  input  logic                                                  i_capture,
  input  logic                                                  i_ready,
  output logic                                                  o_valid,
  output logic [ADDR_WIDTH-1:0]                                 o_addr,
  output logic [DATA_WIDTH-1:0]                                 o_data,
  output logic [IDX_WIDTH-1:0]                                  o_idx,
  output logic                                                  o_busy,
  output logic                                                  o_done,
  output logic                                                  o_overrun
);

  localparam int                   WW       = word_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

  state_e                  state_q, state_d;
  logic [NUM_PE*WW-1:0]    snap_q, snap_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    overrun_q, overrun_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_WIDTH-1:0]    oidx_q, oidx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_null;
  logic                    emit;

  // Select from next-state snapshot/index so the output registers load the
  // word that will be current next cycle (keeps capture-to-valid at 1 cycle).
  nanci_word_select #(
    .NUM_PE     (NUM_PE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_sel (
    .col_i  (snap_d),
    .idx_i  (idx_d),
    .addr_o (sel_addr),
    .data_o (sel_data),
    .null_o (sel_null)
  );

`ifdef NANCI_COLLECT_FILTER_EN
  assign emit = !sel_null;
`else
  logic unused_null;
  assign unused_null = sel_null;
  assign emit        = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (i_capture) begin
          snap_d  = i_PE_col;
          idx_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_capture) overrun_d = 1'b1;
        // A suppressed (null) word has valid low and still consumes its cycle.
        if (!valid_q || i_ready) begin
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_capture) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == ST_DRAIN) && emit;
    addr_d  = (state_d == ST_DRAIN) ? sel_addr : '0;
    data_d  = (state_d == ST_DRAIN) ? sel_data : '0;
    oidx_d  = (state_d == ST_DRAIN) ? idx_d    : '0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      oidx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      oidx_q    <= oidx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_idx     = oidx_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_nanci_result_collector.sv
// Bench for nanci_result_collector: directed and randomized drains checked
// against a per-cycle timeline derived from the word list and ready pattern.
module tb_nanci_result_collector;

  localparam int NP   = 4;
  localparam int AW   = 3;
  localparam int DW   = 3;
  localparam int WW   = AW + DW;
  localparam int IW   = 2;
  localparam int MAXC = 64;
`ifdef NANCI_COLLECT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*WW-1:0] i_PE_col;
  logic             i_capture;
  logic             i_ready;
  logic             o_valid;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_data;
  logic [IW-1:0]    o_idx;
  logic             o_busy;
  logic             o_done;
  logic             o_overrun;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  nanci_result_collector #(
    .NUM_PE     (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_PE_col  (i_PE_col),
    .i_capture (i_capture),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_idx     (o_idx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   32'(o_valid),   32'd0);
    chk({tag, "_addr"},    32'(o_addr),    32'd0);
    chk({tag, "_data"},    32'(o_data),    32'd0);
    chk({tag, "_idx"},     32'(o_idx),     32'd0);
    chk({tag, "_busy"},    32'(o_busy),    32'd0);
    chk({tag, "_done"},    32'(o_done),    32'd0);
    chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
  endtask

  // Capture col, then follow the expected timeline: ready pattern low in
  // cycles lo..hi (or random when rnd), optional input change at cycle 1,
  // optional extra capture at cycle ovr_at (0 = none).
  task automatic run_drain(input logic [NP*WW-1:0] col, input int lo, input int hi,
                           input bit rnd, input bit isolate, input int ovr_at);
    logic          rdy  [MAXC];
    logic          ev   [MAXC];
    logic          edr  [MAXC];
    int            eidx [MAXC];
    int            c;
    logic          acc;
    logic [WW-1:0] w;
    for (int i = 0; i < MAXC; i++) begin
      if (i >= 32)  rdy[i] = 1'b1;
      else if (rnd) rdy[i] = ($urandom_range(0, 2) != 0);
      else          rdy[i] = !(i >= lo && i <= hi);
      ev[i] = 1'b0; edr[i] = 1'b0; eidx[i] = 0;
    end
    c = 1;
    for (int k = 0; k < NP; k++) begin
      w = col[k*WW +: WW];
      if (FILT && (w[WW-1 -: AW] == {AW{1'b1}})) begin
        edr[c] = 1'b1; eidx[c] = k; c++;
      end else begin
        acc = 1'b0;
        while (!acc) begin
          ev[c] = 1'b1; edr[c] = 1'b1; eidx[c] = k;
          acc = rdy[c];
          c++;
        end
      end
    end
    // c is now the cycle in which o_done is expected
    i_PE_col  = col;
    i_capture = 1'b1;
    i_ready   = 1'b1;
    @(posedge clk); #1;
    i_capture = 1'b0;
    for (int t = 1; t <= c + 1; t++) begin
      i_ready   = rdy[t];
      if (isolate && t == 1) i_PE_col = {NP{6'b000111}};
      i_capture = (t == ovr_at) && (t <= c);
      @(negedge clk);
      chk("valid", 32'(o_valid), 32'(ev[t]));
      if (ev[t]) begin
        w = col[eidx[t]*WW +: WW];
        chk("addr", 32'(o_addr), 32'(w[WW-1 -: AW]));
        chk("data", 32'(o_data), 32'(w[DW-1:0]));
        chk("idx",  32'(o_idx),  32'(eidx[t]));
      end else if (edr[t]) begin
        chk("skip_idx", 32'(o_idx), 32'(eidx[t]));
      end
      chk("busy",    32'(o_busy),    32'(t <= c));
      chk("done",    32'(o_done),    32'(t == c));
      chk("overrun", 32'(o_overrun), 32'(exp_ovr));
      @(posedge clk); #1;
      if (i_capture) exp_ovr = 1'b1;
    end
    i_capture = 1'b0;
  endtask

  logic [NP*WW-1:0] basic_col;
  logic [NP*WW-1:0] filt_col;
  logic [NP*WW-1:0] rcol;
  logic [WW-1:0]    rw;

  initial begin
    basic_col = {6'b100101, 6'b011100, 6'b010011, 6'b001010};
    filt_col  = {6'b100101, 6'b111000, 6'b010011, 6'b111001};
    rst_n     = 1'b0;
    i_PE_col  = '0;
    i_capture = 1'b0;
    i_ready   = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_drain(basic_col, 0, -1, 1'b0, 1'b0, 0);  // basic
    run_drain(basic_col, 2, 4,  1'b0, 1'b0, 0);  // backpressure
    run_drain(basic_col, 0, -1, 1'b0, 1'b1, 0);  // snapshot isolation
    run_drain(basic_col, 0, -1, 1'b0, 1'b0, 2);  // overrun
    run_drain(basic_col, 0, -1, 1'b0, 1'b0, 0);  // fresh drain after overrun
    run_drain(filt_col,  0, -1, 1'b0, 1'b0, 0);  // null-address words
    run_drain({NP{6'b111010}}, 0, -1, 1'b0, 1'b0, 0);

    // Reset mid-drain
    i_PE_col  = basic_col;
    i_capture = 1'b1;
    i_ready   = 1'b1;
    @(posedge clk); #1;
    i_capture = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_ovr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_drain(basic_col, 0, -1, 1'b0, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NP; k++) begin
        rw = WW'($urandom);
        if ($urandom_range(0, 2) == 0) rw[WW-1 -: AW] = {AW{1'b1}};
        rcol[k*WW +: WW] = rw;
      end
      run_drain(rcol, 0, -1, 1'b1, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
